ped_crossing_ctrl: RTL and testbench
====================================

PED_CROSSING_CTRL -- requirements
Module: ped_crossing_ctrl

Interface
REQ-001 Parameter WALK_CYCLES, default 5: cycles the walk lamp stays on; legal range 1..15.
REQ-002 Parameter CLEAR_CYCLES, default 4: cycles of the flashing don't-walk clearance phase; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-005 red  input  1  vehicle red lamp from the traffic light controller, synchronous to clk.
REQ-006 green  input  1  vehicle green lamp, synchronous to clk.
REQ-007 yellow  input  1  vehicle yellow lamp, synchronous to clk.
REQ-008 ped_btn  input  1  raw, asynchronous pedestrian push-button, active-high.
REQ-009 walk_lamp  output  1  pedestrian WALK indication.
REQ-010 dw_lamp  output  1  pedestrian DON'T-WALK indication, steady or flashing.
REQ-011 countdown  output  4  clearance cycles remaining; 0 outside clearance.
REQ-012 req_pending  output  1  a latched pedestrian request awaits service.
REQ-013 fault  output  1  sticky fault flag.

Function
REQ-014 The block SHALL pass ped_btn through a two-flop synchronizer, then detect rising edges on the synchronized signal with a third flop.
REQ-015 req_pending SHALL set on the edge where a synchronized rising edge is detected, i.e. 3 edges after ped_btn is first sampled high; holding or re-pressing the button while pending has no further effect.
REQ-016 The block SHALL register red each cycle (red_d); a red start SHALL be defined as red=1 and red_d=0.
REQ-017 The FSM SHALL have states IDLE, WALK, CLEAR and FAULT.
REQ-018 IDLE->WALK SHALL occur on the edge where a red start coincides with req_pending=1 or with a same-cycle synchronized button edge; req_pending SHALL clear on that same edge.
REQ-019 A request raised while red is already high (no red start) SHALL wait for the next red start.
REQ-020 WALK SHALL last exactly WALK_CYCLES cycles, then go to CLEAR.
REQ-021 CLEAR SHALL last exactly CLEAR_CYCLES cycles, then go to IDLE.
REQ-022 A button press during WALK or CLEAR SHALL set req_pending for service at a later red start.
REQ-023 The phase counter SHALL be 4 bits, load on each state entry, and never wrap.
REQ-024 Outputs SHALL be Moore, decoded from registered state only.
REQ-025 IDLE: walk_lamp=0, dw_lamp=1, countdown=0.
REQ-026 WALK: walk_lamp=1, dw_lamp=0, countdown=0.
REQ-027 CLEAR: walk_lamp=0; dw_lamp=1 on the first CLEAR cycle and toggling every cycle; countdown=CLEAR_CYCLES on the first CLEAR cycle, decrementing by 1 per cycle to 1 on the last.
REQ-028 FAULT: walk_lamp=0, dw_lamp=1 steady, countdown=0, fault=1.
REQ-029 A sampled {red, green, yellow} that is not exactly one-hot SHALL cause a transition to FAULT on that edge, from any state.
REQ-030 red=0 sampled while in WALK or CLEAR SHALL cause a transition to FAULT on that edge.
REQ-031 red falling on the same edge that CLEAR completes SHALL NOT be a fault, because red is still 1 in the sampled cycle.
REQ-032 FAULT SHALL be exited only by reset; req_pending SHALL still latch in FAULT but SHALL NOT be serviced.
REQ-033 If a fault condition and a phase-end transition coincide, FAULT SHALL win.

Reset
REQ-034 Reset SHALL force state=IDLE, walk_lamp=0, dw_lamp=1, countdown=0, req_pending=0, fault=0, clear the synchronizer/edge flops, and clear red_d to 0.
REQ-035 Reset asserted mid-WALK or mid-CLEAR SHALL drop walk_lamp immediately (asynchronously) and discard the pending request.
REQ-036 After reset release, a red already high in the first sampled cycle SHALL count as a red start.

Verification
REQ-037 Press ped_btn for 2 cycles during green; the light then goes red for 10 cycles -> req_pending=1 3 edges after press; walk_lamp=1 for 5 cycles from the cycle after the red start; countdown 4,3,2,1 with dw_lamp 1,0,1,0; IDLE as red falls; fault=0.
REQ-038 No press through a full red/green/yellow cycle -> walk_lamp stays 0, dw_lamp stays 1, countdown stays 0.
REQ-039 Press mid-red (no red start pending) -> no WALK in this red; WALK begins at the next red start.
REQ-040 Drive red=1 and green=1 for one cycle in IDLE -> fault=1 and dw_lamp=1 from the next edge; fault holds after the inputs return legal; only reset clears it.
REQ-041 Drop red in the 3rd WALK cycle -> next edge state=FAULT, walk_lamp=0.
REQ-042 Assert reset in the 2nd CLEAR cycle -> countdown=0, dw_lamp=1, req_pending=0 immediately; normal operation resumes at the next red start with a request.

Source files
------------

// File: rtl/ped_crossing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ped_crossing_ctrl
// Brief    : Pedestrian crossing controller that shadows a vehicle light;
//            services latched button requests at the start of each red phase.
// Revision : 1.0 - initial release
// ============================================================================
module ped_crossing_ctrl #(
  parameter int WALK_CYCLES  = 5,
  parameter int CLEAR_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       red,
  input  logic       green,
  input  logic       yellow,
  input  logic       ped_btn,
  output logic       walk_lamp,
  output logic       dw_lamp,
  output logic [3:0] countdown,
  output logic       req_pending,
  output logic       fault
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WALK  = 2'd1;
  localparam logic [1:0] c_CLEAR = 2'd2;
  localparam logic [1:0] c_FAULT = 2'd3;

  localparam logic [3:0] c_WALK_LOAD  = 4'(WALK_CYCLES);
  localparam logic [3:0] c_CLEAR_LOAD = 4'(CLEAR_CYCLES);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_sync3;
  logic       r_red_d;
  logic       r_req_pending;
  logic [1:0] r_state;
  logic [3:0] r_cnt;

  logic       w_btn_edge;
  logic       w_red_start;
  logic       w_lamps_bad;
  logic [1:0] w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_pending_nxt;

  assign w_btn_edge  = r_sync2 & ~r_sync3;
  assign w_red_start = red & ~r_red_d;
  assign w_lamps_bad = ({red, green, yellow} != 3'b100) &&
                       ({red, green, yellow} != 3'b010) &&
                       ({red, green, yellow} != 3'b001);

  // Fault checks sit first in every branch so they win over phase-end moves.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_req_pending | w_btn_edge;
    case (r_state)
      c_IDLE: begin
        if (w_lamps_bad) begin
          w_state_nxt = c_FAULT;
          w_cnt_nxt   = 4'd0;
        end else if (w_red_start && (r_req_pending || w_btn_edge)) begin
          w_state_nxt   = c_WALK;
          w_cnt_nxt     = c_WALK_LOAD;
          w_pending_nxt = 1'b0;
        end
      end
      c_WALK: begin
        if (w_lamps_bad || !red) begin
          w_state_nxt = c_FAULT;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt <= 4'd1) begin
          w_state_nxt = c_CLEAR;
          w_cnt_nxt   = c_CLEAR_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      c_CLEAR: begin
        if (w_lamps_bad || !red) begin
          w_state_nxt = c_FAULT;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt <= 4'd1) begin
          w_state_nxt = c_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = c_FAULT;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_sync3       <= 1'b0;
      r_red_d       <= 1'b0;
      r_req_pending <= 1'b0;
      r_state       <= c_IDLE;
      r_cnt         <= 4'd0;
    end else begin
      r_sync1       <= ped_btn;
      r_sync2       <= r_sync1;
      r_sync3       <= r_sync2;
      r_red_d       <= red;
      r_req_pending <= w_pending_nxt;
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  // Flash phase: lamp on whenever the count has the same parity as its load.
  assign walk_lamp   = (r_state == c_WALK);
  assign dw_lamp     = (r_state != c_WALK) &&
                       !((r_state == c_CLEAR) && (r_cnt[0] ^ c_CLEAR_LOAD[0]));
  assign countdown   = (r_state == c_CLEAR) ? r_cnt : 4'd0;
  assign req_pending = r_req_pending;
  assign fault       = (r_state == c_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_ped_crossing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ped_crossing_ctrl
// Brief    : Directed and randomized checks of ped_crossing_ctrl against a
//            timeline-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ped_crossing_ctrl;

  localparam int W = 5;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       red;
  logic       green;
  logic       yellow;
  logic       ped_btn;
  logic       walk_lamp;
  logic       dw_lamp;
  logic [3:0] countdown;
  logic       req_pending;
  logic       fault;

  int n_cmp = 0;
  int n_bad = 0;
  int btn_left = 0;
  bit rnd_btn = 0;

  int exp_walk[10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  int exp_cd[10]   = '{0, 0, 0, 0, 0, 4, 3, 2, 1, 0};
  int exp_dw[10]   = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1};

  ped_crossing_ctrl #(.WALK_CYCLES(W), .CLEAR_CYCLES(C)) dut (
    .clk(clk), .reset(reset), .red(red), .green(green), .yellow(yellow),
    .ped_btn(ped_btn), .walk_lamp(walk_lamp), .dw_lamp(dw_lamp),
    .countdown(countdown), .req_pending(req_pending), .fault(fault)
  );

  always #5 clk = ~clk;

  // Model: a service is a timeline of edges since the red start that began it.
  bit m_fault, m_active, m_pending, m_red_prev;
  int m_since;
  bit btn_log[$];

  function automatic bit smp(int ago);
    if (btn_log.size() > ago) return btn_log[btn_log.size() - 1 - ago];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_fault = 0; m_active = 0; m_pending = 0; m_red_prev = 0; m_since = 0;
    btn_log.delete();
  endtask

  task automatic model_edge(bit r, bit g, bit y, bit b);
    bit saw_press, red_start, bad, busy;
    saw_press = smp(1) && !smp(2);
    red_start = r && !m_red_prev;
    bad       = (int'(r) + int'(g) + int'(y)) != 1;
    busy      = !m_fault && m_active;
    if (m_fault) begin
      m_pending |= saw_press;
    end else if (bad || (busy && !r)) begin
      m_fault = 1; m_active = 0; m_pending |= saw_press;
    end else if (busy) begin
      m_since++;
      if (m_since >= W + C) m_active = 0;
      m_pending |= saw_press;
    end else if (red_start && (m_pending || saw_press)) begin
      m_active = 1; m_since = 0; m_pending = 0;
    end else begin
      m_pending |= saw_press;
    end
    m_red_prev = r;
    btn_log.push_back(b);
    if (btn_log.size() > 8) void'(btn_log.pop_front());
  endtask

  task automatic model_expect(output int ew, output int ed, output int ec,
                              output int ep, output int ef);
    ew = 0; ed = 1; ec = 0; ep = int'(m_pending); ef = int'(m_fault);
    if (!m_fault && m_active) begin
      if (m_since < W) begin
        ew = 1; ed = 0;
      end else begin
        ec = C - (m_since - W);
        ed = (((m_since - W) % 2) == 0) ? 1 : 0;
      end
    end
  endtask

  task automatic check(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic compare_all();
    int ew, ed, ec, ep, ef;
    model_expect(ew, ed, ec, ep, ef);
    check("walk_lamp", int'(walk_lamp), ew);
    check("dw_lamp", int'(dw_lamp), ed);
    check("countdown", int'(countdown), ec);
    check("req_pending", int'(req_pending), ep);
    check("fault", int'(fault), ef);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(red, green, yellow, ped_btn);
    @(negedge clk);
    compare_all();
  endtask

  task automatic lights(bit r, bit g, bit y);
    red = r; green = g; yellow = y;
  endtask

  task automatic phase(bit r, bit g, bit y, int n);
    lights(r, g, y);
    repeat (n) begin
      if (btn_left > 0) begin
        ped_btn = 1; btn_left--;
      end else begin
        ped_btn = 0;
        if (rnd_btn && $urandom_range(0, 9) == 0) btn_left = $urandom_range(1, 4);
      end
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    model_reset();
    compare_all();
    tick();
    tick();
    reset = 0;
  endtask

  task automatic press2();
    ped_btn = 1; tick(); tick(); ped_btn = 0; tick();
  endtask

  initial begin
    reset = 0; ped_btn = 0; lights(0, 1, 0);
    #1 reset = 1;
    #1;
    model_reset();
    check("rst_walk", int'(walk_lamp), 0);
    check("rst_dw", int'(dw_lamp), 1);
    check("rst_countdown", int'(countdown), 0);
    check("rst_pending", int'(req_pending), 0);
    check("rst_fault", int'(fault), 0);
    compare_all();
    tick(); tick();
    reset = 0;

    // Basic service: 2-cycle press in green, then 10 cycles of red.
    phase(0, 1, 0, 3);
    ped_btn = 1; tick(); check("press_e0_pending", int'(req_pending), 0);
    tick();              check("press_e1_pending", int'(req_pending), 0);
    ped_btn = 0; tick(); check("press_e2_pending", int'(req_pending), 1);
    tick();
    phase(0, 0, 1, 2);
    lights(1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("svc_walk[%0d]", i), int'(walk_lamp), exp_walk[i]);
      check($sformatf("svc_cd[%0d]", i), int'(countdown), exp_cd[i]);
      check($sformatf("svc_dw[%0d]", i), int'(dw_lamp), exp_dw[i]);
      if (i == 0) check("svc_pending_cleared", int'(req_pending), 0);
    end
    phase(0, 1, 0, 1);
    check("svc_end_fault", int'(fault), 0);

    // No press through a full cycle.
    phase(0, 1, 0, 2);
    phase(0, 0, 1, 2);
    phase(1, 0, 0, 12);
    check("nopress_walk", int'(walk_lamp), 0);
    check("nopress_cd", int'(countdown), 0);

    // Press mid-red: waits for the next red start.
    phase(0, 1, 0, 3);
    phase(1, 0, 0, 3);
    press2();
    phase(1, 0, 0, 8);
    check("midred_pending", int'(req_pending), 1);
    check("midred_walk", int'(walk_lamp), 0);
    phase(0, 1, 0, 3);
    phase(0, 0, 1, 1);
    phase(1, 0, 0, 1);
    check("nextred_walk", int'(walk_lamp), 1);
    phase(1, 0, 0, 10);

    // Red dropped in the 3rd walk cycle.
    phase(0, 1, 0, 2);
    press2();
    phase(0, 0, 1, 1);
    phase(1, 0, 0, 3);
    check("walk3_walk", int'(walk_lamp), 1);
    phase(0, 1, 0, 1);
    check("reddrop_walk", int'(walk_lamp), 0);
    check("reddrop_fault", int'(fault), 1);
    do_reset();

    // Non-one-hot lamps in IDLE; fault is sticky and requests are not serviced.
    phase(0, 1, 0, 3);
    phase(1, 1, 0, 1);
    check("badlamp_fault", int'(fault), 1);
    check("badlamp_dw", int'(dw_lamp), 1);
    phase(0, 1, 0, 2);
    press2();
    phase(0, 1, 0, 1);
    check("fault_pending", int'(req_pending), 1);
    phase(1, 0, 0, 3);
    check("fault_no_walk", int'(walk_lamp), 0);
    check("fault_sticky", int'(fault), 1);
    do_reset();
    check("fault_cleared", int'(fault), 0);

    // Reset in the 2nd clear cycle with a request pending.
    phase(0, 1, 0, 2);
    press2();
    phase(0, 0, 1, 1);
    phase(1, 0, 0, 1);
    ped_btn = 1; tick(); tick(); ped_btn = 0;
    phase(1, 0, 0, 4);
    check("clr2_cd", int'(countdown), 3);
    check("clr2_pending", int'(req_pending), 1);
    reset = 1;
    #1;
    check("async_cd", int'(countdown), 0);
    check("async_dw", int'(dw_lamp), 1);
    check("async_pending", int'(req_pending), 0);
    check("async_walk", int'(walk_lamp), 0);
    model_reset();
    tick(); tick();
    reset = 0;
    phase(1, 0, 0, 2);
    phase(0, 1, 0, 2);
    press2();
    phase(0, 0, 1, 1);
    phase(1, 0, 0, 1);
    check("resume_walk", int'(walk_lamp), 1);
    phase(1, 0, 0, 10);

    // Randomized traffic with random presses, short reds and bad lamp patterns.
    rnd_btn = 1;
    for (int i = 0; i < 60; i++) begin
      phase(0, 1, 0, $urandom_range(2, 8));
      phase(0, 0, 1, $urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) phase(1, 0, 1, 1);
      phase(1, 0, 0, $urandom_range(4, 20));
      if (m_fault) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
